// File: rtl/mvm_pkg.sv
// Shared types and constants for the mat-vec loader: FSM state encoding,
// default geometry and the byte-lane offset helper.
package mvm_pkg;

   localparam int MVM_DATA_WIDTH = 8;
   localparam int MVM_NUM_MACS   = 8;

   // Row index that addresses the vector (B) word, for the default geometry
   localparam int ROW_B = MVM_NUM_MACS;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      REQ,
      RESP,
      PUSH,
      ARM,
      WAIT_DONE,
      CAPTURE
   } mvm_ld_state_t;

   // Bit offset of byte lane k inside a packed word of width-bit lanes
   function automatic int lane_lsb(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/mvm_word_serializer.sv
// Holds one memory word and presents it one byte lane at a time.
// The lane index advances only when the consumer is not stalled, so a
// stalled lane is neither dropped nor repeated.
module mvm_word_serializer
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH = MVM_DATA_WIDTH,
   parameter int NUM_MACS   = MVM_NUM_MACS
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           load,
   input  logic [NUM_MACS*DATA_WIDTH-1:0] word,
   input  logic                           step,
   input  logic                           stall,
   output logic [DATA_WIDTH-1:0]          lane,
   output logic                           last
);

   localparam int IDX_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MACS - 1);

   logic [NUM_MACS*DATA_WIDTH-1:0] word_q;
   logic [IDX_W-1:0]               idx;
   logic                           advance;

   assign advance = step & ~stall;
   assign last    = (idx == IDX_LAST);
   assign lane    = word_q[lane_lsb(int'(idx), DATA_WIDTH) +: DATA_WIDTH];

   // Word holding register: data only, refreshed on each load
   always_ff @(posedge clk) begin
      if (load) begin
         word_q <= word;
      end
   end

   // Lane index: restarts on load, wraps after the last lane is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (load) begin
         idx <= '0;
      end else if (advance) begin
         idx <= last ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/mvm_loader.sv
// Producer side of the mat-vec engine: fetches NUM_MACS matrix rows plus
// one vector word, streams them byte-wise into FIFOs A[r] and B, starts the
// engine, then captures its results or flags a timeout.
module mvm_loader
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH     = MVM_DATA_WIDTH,
   parameter int NUM_MACS       = MVM_NUM_MACS,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             go,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic                             mem_read,
   input  logic                             mem_waitrequest,
   input  logic [NUM_MACS*DATA_WIDTH-1:0]   mem_readdata,
   input  logic                             mem_readdatavalid,
   output logic [NUM_MACS*DATA_WIDTH-1:0]   fifo_a_data,
   output logic [NUM_MACS-1:0]              fifo_a_wren,
   input  logic [NUM_MACS-1:0]              fifo_a_full,
   output logic [DATA_WIDTH-1:0]            fifo_b_data,
   output logic                             fifo_b_wren,
   input  logic                             fifo_b_full,
   input  logic                             all_fifos_full,
   output logic                             clr_accum,
   output logic                             start_compute,
   input  logic                             compute_done,
   input  logic [NUM_MACS*3*DATA_WIDTH-1:0] mac_out,
   output logic [NUM_MACS*3*DATA_WIDTH-1:0] result,
   output logic                             result_valid
);

   localparam int ROW_W = $clog2(NUM_MACS + 2);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ROW_W-1:0] ROW_VEC  = ROW_W'(NUM_MACS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   mvm_ld_state_t           state, state_nx;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ROW_W-1:0]        row;
   logic [TMO_W-1:0]        tmo;
   logic                    err_q;
   logic [NUM_MACS-1:0]     row_sel;
   logic                    row_is_b;
   logic                    target_full;
   logic                    in_push;
   logic                    push_fire;
   logic                    ser_load;
   logic                    ser_last;
   logic [DATA_WIDTH-1:0]   ser_lane;
   logic                    accept_go;
   logic                    capture_en;
   logic                    timeout_hit;

   // Row r < NUM_MACS targets FIFO A[r]; row NUM_MACS is the vector word
   assign row_is_b    = (row == ROW_VEC);
   assign target_full = row_is_b ? fifo_b_full : |(fifo_a_full & row_sel);
   assign in_push     = (state == PUSH);
   assign push_fire   = in_push & ~target_full;

   assign busy = (state != IDLE);
   assign err  = err_q | timeout_hit;

   mvm_word_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_MACS   (NUM_MACS)
   ) u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ser_load),
      .word  (mem_readdata),
      .step  (in_push),
      .stall (target_full),
      .lane  (ser_lane),
      .last  (ser_last)
   );

   // One-hot decode of the current row onto the A FIFOs
   always_comb begin
      row_sel = '0;
      for (int i = 0; i < NUM_MACS; i++) begin
         row_sel[i] = (row == ROW_W'(i));
      end
   end

   // FIFO write ports: only the targeted FIFO sees data, and only while pushing
   always_comb begin
      fifo_a_data = '0;
      fifo_a_wren = '0;
      for (int i = 0; i < NUM_MACS; i++) begin
         if (in_push && row_sel[i]) begin
            fifo_a_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = ser_lane;
         end
         fifo_a_wren[i] = push_fire & row_sel[i];
      end
   end

   assign fifo_b_data = (in_push && row_is_b) ? ser_lane : '0;
   assign fifo_b_wren = push_fire & row_is_b;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      state_nx      = state;
      mem_read      = 1'b0;
      mem_addr      = '0;
      clr_accum     = 1'b0;
      start_compute = 1'b0;
      done          = 1'b0;
      result_valid  = 1'b0;
      ser_load      = 1'b0;
      accept_go     = 1'b0;
      capture_en    = 1'b0;
      timeout_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               accept_go = 1'b1;
               state_nx  = CLEAR;
            end
         end
         CLEAR: begin
            clr_accum = 1'b1;
            state_nx  = REQ;
         end
         REQ: begin
            // Request and address stay put until the memory accepts them
            mem_read = 1'b1;
            mem_addr = base_q + ADDR_WIDTH'(row);
            if (!mem_waitrequest) begin
               state_nx = RESP;
            end
         end
         RESP: begin
            if (mem_readdatavalid) begin
               ser_load = 1'b1;
               state_nx = PUSH;
            end
         end
         PUSH: begin
            if (push_fire && ser_last) begin
               state_nx = row_is_b ? ARM : REQ;
            end
         end
         ARM: begin
            if (all_fifos_full) begin
               start_compute = 1'b1;
               state_nx      = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (compute_done) begin
               capture_en = 1'b1;
               state_nx   = CAPTURE;
            end else if (tmo == TMO_LAST) begin
               timeout_hit = 1'b1;
               done        = 1'b1;
               state_nx    = IDLE;
            end
         end
         CAPTURE: begin
            result_valid = 1'b1;
            done         = 1'b1;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Job control: base latch, row counter, timeout counter, sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         row    <= '0;
         tmo    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept_go) begin
            base_q <= base_addr;
            row    <= '0;
            err_q  <= 1'b0;
         end else if (push_fire && ser_last) begin
            row <= row + ROW_W'(1);
         end
         if (start_compute) begin
            tmo <= '0;
         end else if (state == WAIT_DONE && !compute_done && !timeout_hit) begin
            tmo <= tmo + TMO_W'(1);
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   // Result capture: loaded on the edge into CAPTURE so it is valid with result_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
      end else if (capture_en) begin
         result <= mac_out;
      end
   end

endmodule

// File: tb/tb_mvm_loader.sv
// Directed bench for mvm_loader with a memory model, FIFO models and a
// behavioural engine that forms the dot products from the FIFO contents.
module tb_mvm_loader;

   localparam int NM = 8;
   localparam int DW = 8;
   localparam int RW = 3 * DW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             go = 1'b0;
   logic [31:0]      base_addr = '0;
   logic             busy, done, err;
   logic [31:0]      mem_addr;
   logic             mem_read;
   logic             mem_waitrequest;
   logic [NM*DW-1:0] mem_readdata = '0;
   logic             mem_readdatavalid = 1'b0;
   logic [NM*DW-1:0] fifo_a_data;
   logic [NM-1:0]    fifo_a_wren;
   logic [NM-1:0]    fifo_a_full;
   logic [DW-1:0]    fifo_b_data;
   logic             fifo_b_wren;
   logic             fifo_b_full;
   logic             all_fifos_full;
   logic             clr_accum, start_compute;
   logic             compute_done = 1'b0;
   logic [NM*RW-1:0] mac_out = '0;
   logic [NM*RW-1:0] result;
   logic             result_valid;

   // bench controls (driven from the initial block)
   logic stats_clr = 1'b0;
   int   stall_cfg = 0;
   int   pat = 0;
   logic eng_en = 1'b1;
   logic force_arm = 1'b0;

   // model state / statistics
   int          cyc = 0;
   int          stall_cnt = 0;
   logic        rd_pending = 1'b0;
   logic [31:0] rd_addr = '0;
   logic [31:0] reads [$];
   logic        stalled = 1'b0;
   logic [31:0] stalled_addr = '0;
   int          stall_viol = 0, stall_cyc = 0;
   logic [7:0]  fa [NM][$];
   logic [7:0]  fb [$];
   int          cnt_a [NM];
   int          cnt_b = 0;
   int          wr_a_total = 0, wr_b_total = 0, full_wr_viol = 0;
   int          clr_cnt = 0, sc_cnt = 0, done_cnt = 0, rv_cnt = 0;
   int          sc_cyc = 0, done_cyc = 0, eng_timer = 0;
   int          force_cnt = 0, force_viol = 0;
   logic [7:0]  held_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [119:0] outs;
   assign outs = {busy, done, err, mem_read, mem_addr, fifo_a_wren, fifo_a_data,
                  fifo_b_wren, fifo_b_data, clr_accum, start_compute, result_valid};

   mvm_loader #(
      .DATA_WIDTH     (DW),
      .NUM_MACS       (NM),
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .go                (go),
      .base_addr         (base_addr),
      .busy              (busy),
      .done              (done),
      .err               (err),
      .mem_addr          (mem_addr),
      .mem_read          (mem_read),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .fifo_a_data       (fifo_a_data),
      .fifo_a_wren       (fifo_a_wren),
      .fifo_a_full       (fifo_a_full),
      .fifo_b_data       (fifo_b_data),
      .fifo_b_wren       (fifo_b_wren),
      .fifo_b_full       (fifo_b_full),
      .all_fifos_full    (all_fifos_full),
      .clr_accum         (clr_accum),
      .start_compute     (start_compute),
      .compute_done      (compute_done),
      .mac_out           (mac_out),
      .result            (result),
      .result_valid      (result_valid)
   );

   always #5 clk = ~clk;

   // pat 0: A[i][j]=i+1, B[j]=1.  pat 1: A[i][j]=(i+1)+16j, B[j]=j+1.
   function automatic logic [NM*DW-1:0] mem_word(input logic [31:0] addr);
      logic [NM*DW-1:0] w;
      int off;
      w = '0;
      off = int'(addr - 32'h100);
      for (int j = 0; j < NM; j++) begin
         if (off >= 0 && off < NM)
            w[j*DW +: DW] = (pat == 1) ? 8'(off + 1 + 16 * j) : 8'(off + 1);
         else if (off == NM)
            w[j*DW +: DW] = (pat == 1) ? 8'(j + 1) : 8'd1;
      end
      return w;
   endfunction

   function automatic logic [RW-1:0] mac_of(input int i);
      logic [RW-1:0] acc;
      acc = '0;
      for (int j = 0; j < NM; j++)
         if (j < fa[i].size() && j < fb.size())
            acc = acc + RW'(fa[i][j]) * RW'(fb[j]);
      return acc;
   endfunction

   assign mem_waitrequest = mem_read && (stall_cnt < stall_cfg);

   always_comb begin
      all_fifos_full = (cnt_b >= NM);
      fifo_b_full    = (cnt_b >= NM);
      for (int i = 0; i < NM; i++) begin
         fifo_a_full[i] = (cnt_a[i] >= NM) || (i == 3 && force_cnt > 0);
         if (cnt_a[i] < NM) all_fifos_full = 1'b0;
      end
   end

   // memory, FIFO and engine models plus statistics
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (stats_clr) begin
         stall_cnt <= 0; rd_pending <= 1'b0; mem_readdatavalid <= 1'b0;
         reads.delete(); stalled <= 1'b0; stall_viol <= 0; stall_cyc <= 0;
         for (int i = 0; i < NM; i++) begin fa[i].delete(); cnt_a[i] <= 0; end
         fb.delete(); cnt_b <= 0;
         wr_a_total <= 0; wr_b_total <= 0; full_wr_viol <= 0;
         clr_cnt <= 0; sc_cnt <= 0; done_cnt <= 0; rv_cnt <= 0;
         eng_timer <= 0; compute_done <= 1'b0; mac_out <= '0;
         force_cnt <= 0; force_viol <= 0; held_q.delete();
      end else begin
         mem_readdatavalid <= 1'b0;
         if (rd_pending) begin
            mem_readdatavalid <= 1'b1;
            mem_readdata      <= mem_word(rd_addr);
            rd_pending        <= 1'b0;
         end
         if (mem_read && !mem_waitrequest) begin
            rd_pending <= 1'b1; rd_addr <= mem_addr;
            reads.push_back(mem_addr); stall_cnt <= 0;
         end else if (mem_read) begin
            stall_cnt <= stall_cnt + 1; stall_cyc <= stall_cyc + 1;
         end
         if (stalled && !(mem_read && mem_addr == stalled_addr)) stall_viol <= stall_viol + 1;
         stalled      <= mem_read && mem_waitrequest;
         stalled_addr <= mem_addr;
         for (int i = 0; i < NM; i++) begin
            if (fifo_a_wren[i]) begin
               if (fifo_a_full[i]) full_wr_viol <= full_wr_viol + 1;
               fa[i].push_back(fifo_a_data[i*DW +: DW]);
               cnt_a[i] <= cnt_a[i] + 1;
            end
         end
         wr_a_total <= wr_a_total + $countones(fifo_a_wren);
         if (fifo_b_wren) begin
            if (fifo_b_full) full_wr_viol <= full_wr_viol + 1;
            fb.push_back(fifo_b_data);
            cnt_b <= cnt_b + 1;
            wr_b_total <= wr_b_total + 1;
         end
         if (force_cnt > 0) begin
            force_cnt <= force_cnt - 1;
            held_q.push_back(fifo_a_data[3*DW +: DW]);
            if (fifo_a_wren[3]) force_viol <= force_viol + 1;
         end else if (force_arm && fifo_a_wren[3] && cnt_a[3] == 3) begin
            force_cnt <= 3;
         end
         if (clr_accum) clr_cnt <= clr_cnt + 1;
         if (start_compute) begin
            sc_cnt <= sc_cnt + 1; sc_cyc <= cyc; eng_timer <= 4;
         end else if (eng_timer > 0) begin
            eng_timer <= eng_timer - 1;
            if (eng_timer == 1 && eng_en) begin
               for (int i = 0; i < NM; i++) mac_out[i*RW +: RW] <= mac_of(i);
               compute_done <= 1'b1;
            end
         end
         if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
         if (result_valid) rv_cnt <= rv_cnt + 1;
      end
   end

   task automatic clear_stats();
      @(negedge clk); stats_clr = 1'b1;
      @(negedge clk); stats_clr = 1'b0;
   endtask

   task automatic start_job(input logic [31:0] b);
      @(negedge clk); go = 1'b1; base_addr = b;
      @(negedge clk); go = 1'b0;
   endtask

   // Returns at the negedge of the done cycle, or ok=0 after the cycle budget
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %0h want 0", outs); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %0h want 0", result); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
   endtask

   task automatic test_basic();
      bit ok;
      pat = 0; stall_cfg = 0;
      clear_stats();
      start_job(32'h100);
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done: got no done want done"); end
      n_cmp++; if (err !== 1'b0 || result_valid !== 1'b1) begin n_bad++; $display("FAIL basic_flags: got err=%0b rv=%0b want err=0 rv=1", err, result_valid); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %0b want 0", busy); end
      n_cmp++; if (reads.size() != 9) begin n_bad++; $display("FAIL basic_nreads: got %0d want 9", reads.size()); end
      for (int k = 0; k < reads.size() && k < 9; k++) begin
         n_cmp++; if (reads[k] !== 32'h100 + 32'(k)) begin n_bad++; $display("FAIL basic_addr%0d: got %0h want %0h", k, reads[k], 32'h100 + k); end
      end
      n_cmp++; if (wr_a_total != 64 || wr_b_total != 8) begin n_bad++; $display("FAIL basic_writes: got a=%0d b=%0d want a=64 b=8", wr_a_total, wr_b_total); end
      n_cmp++; if (clr_cnt != 1 || sc_cnt != 1) begin n_bad++; $display("FAIL basic_pulses: got clr=%0d sc=%0d want 1 1", clr_cnt, sc_cnt); end
      n_cmp++; if (full_wr_viol != 0) begin n_bad++; $display("FAIL basic_overflow: got %0d want 0", full_wr_viol); end
      for (int i = 0; i < NM; i++) begin
         n_cmp++; if (result[i*RW +: RW] !== RW'(8 * (i + 1))) begin n_bad++; $display("FAIL basic_result%0d: got %0d want %0d", i, result[i*RW +: RW], 8 * (i + 1)); end
      end
   endtask

   task automatic test_waitrequest();
      bit ok;
      pat = 0; stall_cfg = 5;
      clear_stats();
      start_job(32'h100);
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wreq_done: got no done want done"); end
      @(negedge clk);
      stall_cfg = 0;
      n_cmp++; if (stall_cyc != 45) begin n_bad++; $display("FAIL wreq_stall_cycles: got %0d want 45", stall_cyc); end
      n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL wreq_stable: got %0d changes want 0", stall_viol); end
      n_cmp++; if (reads.size() != 9) begin n_bad++; $display("FAIL wreq_nreads: got %0d want 9", reads.size()); end
      for (int k = 0; k < reads.size() && k < 9; k++) begin
         n_cmp++; if (reads[k] !== 32'h100 + 32'(k)) begin n_bad++; $display("FAIL wreq_addr%0d: got %0h want %0h", k, reads[k], 32'h100 + k); end
      end
      for (int i = 0; i < NM; i++) begin
         n_cmp++; if (result[i*RW +: RW] !== RW'(8 * (i + 1))) begin n_bad++; $display("FAIL wreq_result%0d: got %0d want %0d", i, result[i*RW +: RW], 8 * (i + 1)); end
      end
   endtask

   task automatic test_fifo_stall();
      bit ok;
      pat = 1; force_arm = 1'b1;
      clear_stats();
      start_job(32'h100);
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done: got no done want done"); end
      @(negedge clk);
      force_arm = 1'b0;
      n_cmp++; if (held_q.size() != 3) begin n_bad++; $display("FAIL stall_cycles: got %0d want 3", held_q.size()); end
      for (int k = 0; k < held_q.size(); k++) begin
         n_cmp++; if (held_q[k] !== 8'd68) begin n_bad++; $display("FAIL stall_held%0d: got %0d want 68", k, held_q[k]); end
      end
      n_cmp++; if (force_viol != 0 || full_wr_viol != 0) begin n_bad++; $display("FAIL stall_wren: got %0d/%0d writes while full want 0", force_viol, full_wr_viol); end
      n_cmp++; if (fa[3].size() != 8) begin n_bad++; $display("FAIL stall_a3_count: got %0d want 8", fa[3].size()); end
      for (int j = 0; j < fa[3].size() && j < 8; j++) begin
         n_cmp++; if (fa[3][j] !== 8'(4 + 16 * j)) begin n_bad++; $display("FAIL stall_a3_byte%0d: got %0d want %0d", j, fa[3][j], 4 + 16 * j); end
      end
      for (int i = 0; i < NM; i++) begin
         n_cmp++; if (result[i*RW +: RW] !== RW'(36 * (i + 1) + 2688)) begin n_bad++; $display("FAIL stall_result%0d: got %0d want %0d", i, result[i*RW +: RW], 36 * (i + 1) + 2688); end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      pat = 0; eng_en = 1'b0;
      clear_stats();
      start_job(32'h100);
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_done: got no done want done"); end
      n_cmp++; if (err !== 1'b1 || result_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_flags: got err=%0b rv=%0b want err=1 rv=0", err, result_valid); end
      @(negedge clk);
      eng_en = 1'b1;
      n_cmp++; if (done_cyc - sc_cyc != 16) begin n_bad++; $display("FAIL tmo_latency: got %0d want 16", done_cyc - sc_cyc); end
      n_cmp++; if (rv_cnt != 0) begin n_bad++; $display("FAIL tmo_rv: got %0d want 0", rv_cnt); end
      n_cmp++; if (busy !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL tmo_after: got busy=%0b err=%0b want busy=0 err=1", busy, err); end
      for (int i = 0; i < NM; i++) begin
         n_cmp++; if (result[i*RW +: RW] !== RW'(36 * (i + 1) + 2688)) begin n_bad++; $display("FAIL tmo_result%0d: got %0d want %0d", i, result[i*RW +: RW], 36 * (i + 1) + 2688); end
      end
   endtask

   task automatic test_go_ignored();
      bit ok;
      bit seen;
      pat = 0;
      clear_stats();
      start_job(32'h100);
      n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL goign_accept: got err=%0b busy=%0b want err=0 busy=1", err, busy); end
      seen = 1'b0;
      for (int n = 0; n < 500 && !seen; n++) begin
         @(negedge clk);
         if (fifo_a_wren != '0) seen = 1'b1;
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL goign_push: got no write want write"); end
      go = 1'b1; base_addr = 32'h200;
      @(negedge clk); go = 1'b0;
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL goign_done: got no done want done"); end
      go = 1'b1; base_addr = 32'h200;
      @(negedge clk); go = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL goign_busy: got %0b want 0", busy); end
      n_cmp++; if (reads.size() != 9 || sc_cnt != 1) begin n_bad++; $display("FAIL goign_reads: got reads=%0d sc=%0d want 9 1", reads.size(), sc_cnt); end
      for (int k = 0; k < reads.size(); k++) begin
         n_cmp++; if (reads[k] !== 32'h100 + 32'(k)) begin n_bad++; $display("FAIL goign_addr%0d: got %0h want %0h", k, reads[k], 32'h100 + k); end
      end
      for (int i = 0; i < NM; i++) begin
         n_cmp++; if (result[i*RW +: RW] !== RW'(8 * (i + 1))) begin n_bad++; $display("FAIL goign_result%0d: got %0d want %0d", i, result[i*RW +: RW], 8 * (i + 1)); end
      end
   endtask

   task automatic test_reset_midjob();
      bit ok;
      bit seen;
      pat = 0;
      clear_stats();
      start_job(32'h100);
      seen = 1'b0;
      for (int n = 0; n < 500 && !seen; n++) begin
         @(negedge clk);
         if (fifo_a_wren[2]) seen = 1'b1;
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_row2: got no write want write"); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %0h want 0", outs); end
      n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rstmid_result: got %0h want 0", result); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      clear_stats();
      start_job(32'h100);
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_done: got no done want done"); end
      @(negedge clk);
      n_cmp++; if (reads.size() != 9) begin n_bad++; $display("FAIL rstmid_nreads: got %0d want 9", reads.size()); end
      if (reads.size() > 0) begin
         n_cmp++; if (reads[0] !== 32'h100) begin n_bad++; $display("FAIL rstmid_first: got %0h want 100", reads[0]); end
      end
      for (int i = 0; i < NM; i++) begin
         n_cmp++; if (result[i*RW +: RW] !== RW'(8 * (i + 1))) begin n_bad++; $display("FAIL rstmid_result%0d: got %0d want %0d", i, result[i*RW +: RW], 8 * (i + 1)); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_waitrequest();
      test_fifo_stall();
      test_timeout();
      test_go_ignored();
      test_reset_midjob();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
